// File: rtl/sprite_pkg.sv
// Shared sprite/OAM definitions: field widths, packed-entry bit offsets and the
// commit FSM state encoding used by the OAM write buffer.
package sprite_pkg;

  localparam int SNUM_W      = 6;
  localparam int INDEX_W     = 6;
  localparam int IMM_W       = 8;
  localparam int XCOOR_W     = 10;
  localparam int YCOOR_W     = 10;
  localparam int OAM_ENTRY_W = INDEX_W + IMM_W + XCOOR_W + YCOOR_W;  // 34
  localparam int QENTRY_W    = SNUM_W + OAM_ENTRY_W;                 // 40

  // Bit offsets inside a queued entry {snum, index, imm, xcoor, ycoor}
  localparam int YCOOR_LSB = 0;
  localparam int XCOOR_LSB = YCOOR_LSB + YCOOR_W;
  localparam int IMM_LSB   = XCOOR_LSB + XCOOR_W;
  localparam int INDEX_LSB = IMM_LSB + IMM_W;
  localparam int SNUM_LSB  = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } oam_state_e;

  function automatic logic [QENTRY_W-1:0] pack_entry(
    input logic [SNUM_W-1:0]  snum,
    input logic [INDEX_W-1:0] index,
    input logic [IMM_W-1:0]   imm,
    input logic [XCOOR_W-1:0] xcoor,
    input logic [YCOOR_W-1:0] ycoor
  );
    return {snum, index, imm, xcoor, ycoor};
  endfunction

endpackage

// File: rtl/oam_write_buffer_if.sv
// CPU-side request bus and OAM-side commit bus of the sprite write buffer.
// master = CPU/PPU environment, slave = the buffer itself.
interface oam_write_buffer_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
);
  import sprite_pkg::*;

  logic                   OAMWrite;
  logic [SNUM_W-1:0]      snum;
  logic [INDEX_W-1:0]     index;
  logic [IMM_W-1:0]       imm;
  logic [XCOOR_W-1:0]     xcoor;
  logic [YCOOR_W-1:0]     ycoor;
  logic                   vblank;
  logic                   oam_full;
  logic                   oam_we;
  logic [SNUM_W-1:0]      oam_addr;
  logic [OAM_ENTRY_W-1:0] oam_data;
  logic [PTR_W:0]         count;
  logic                   overflow;

  modport master (
    output OAMWrite, snum, index, imm, xcoor, ycoor, vblank,
    input  oam_full, oam_we, oam_addr, oam_data, count, overflow
  );

  modport slave (
    input  OAMWrite, snum, index, imm, xcoor, ycoor, vblank,
    output oam_full, oam_we, oam_addr, oam_data, count, overflow
  );

endinterface

// File: rtl/oam_write_buffer_fifo.sv
// Synchronous FIFO with first-word-fall-through read port. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [W-1:0]   i_din,
  output logic [W-1:0]   o_dout,
  output logic           o_push_ok,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [PTR_W:0]   r_count;
  logic             w_push, w_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign o_push_ok = w_push;
  assign o_dout    = r_mem[r_rd];
  assign o_count   = r_count;

  // Storage is not reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/oam_write_buffer.sv
// Queues CPU sprite updates and commits them to OAM only during vblank, one
// entry per cycle, so the PPU never sees a partially updated sprite.
module oam_write_buffer
  import sprite_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  oam_write_buffer_if.slave  bus
);

  logic [QENTRY_W-1:0]    w_din, w_head;
  logic                   w_push_ok, w_full, w_empty, w_pop;
  logic [PTR_W:0]         w_count;

  oam_state_e             r_state;
  logic                   r_we;
  logic [SNUM_W-1:0]      r_addr;
  logic [OAM_ENTRY_W-1:0] r_data;
  logic                   r_overflow;

  assign w_din = pack_entry(bus.snum, bus.index, bus.imm, bus.xcoor, bus.ycoor);
  assign w_pop = (r_state == DRAIN) && bus.vblank && !w_empty;

  sync_fifo #(
    .W     (QENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (bus.OAMWrite),
    .i_pop     (w_pop),
    .i_din     (w_din),
    .o_dout    (w_head),
    .o_push_ok (w_push_ok),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_addr <= w_head[SNUM_LSB +: SNUM_W];
        r_data <= w_head[OAM_ENTRY_W-1:0];
      end
      if (bus.OAMWrite && !w_push_ok) r_overflow <= 1'b1;

      // A push accepted this cycle counts as pending work so a write landing
      // during vblank reaches OAM with the minimum two-cycle latency.
      case (r_state)
        IDLE: begin
          if (bus.vblank)
            r_state <= (!w_empty || w_push_ok) ? DRAIN : DONE;
        end
        DRAIN: begin
          if (!bus.vblank)
            r_state <= IDLE;
          else if (!w_push_ok && w_count <= (PTR_W+1)'(1))
            r_state <= DONE;
        end
        DONE: begin
          if (!bus.vblank)
            r_state <= IDLE;
          else if (w_push_ok || !w_empty)
            r_state <= DRAIN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.oam_full = w_full;
  assign bus.oam_we   = r_we;
  assign bus.oam_addr = r_addr;
  assign bus.oam_data = r_data;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_oam_write_buffer.sv
// Self-checking bench for oam_write_buffer: scoreboard of committed entries,
// a vector table for vblank-time writes, and directed multi-cycle sequences.
module tb_oam_write_buffer;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic [QENTRY_W-1:0] sb[$];

  oam_write_buffer_if #(.DEPTH(8), .PTR_W(3)) bus();

  oam_write_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  snum;
    logic [5:0]  idx;
    logic [7:0]  imm;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [33:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every oam_we pulse must match the oldest accepted entry.
  always @(negedge clk) begin
    if (bus.oam_we === 1'b1) begin
      logic [QENTRY_W-1:0] e;
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_oam_we addr=%0h data=%0h required=none", bus.oam_addr, bus.oam_data);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", 64'(bus.oam_addr), 64'(e[SNUM_LSB +: SNUM_W]));
        chk("sb_data", 64'(bus.oam_data), 64'(e[OAM_ENTRY_W-1:0]));
      end
    end
  end

  task automatic push(input logic [5:0] s, input logic [5:0] idx, input logic [7:0] imm,
                      input logic [9:0] x, input logic [9:0] y, input bit acc);
    bus.OAMWrite = 1'b1;
    bus.snum = s; bus.index = idx; bus.imm = imm; bus.xcoor = x; bus.ycoor = y;
    if (acc) sb.push_back({s, idx, imm, x, y});
    tick();
    bus.OAMWrite = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vblank = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    tick();
    tick();
  endtask

  initial begin
    int p0;
    bus.OAMWrite = 1'b0; bus.snum = '0; bus.index = '0; bus.imm = '0;
    bus.xcoor = '0; bus.ycoor = '0; bus.vblank = 1'b0;

    vecs[0] = '{6'd63, 6'h2A, 8'h3C, 10'd1023, 10'd0,   {6'h2A, 8'h3C, 10'd1023, 10'd0}};
    vecs[1] = '{6'd0,  6'h3F, 8'hFF, 10'd0,    10'd1023, {6'h3F, 8'hFF, 10'd0, 10'd1023}};
    vecs[2] = '{6'd17, 6'h01, 8'h80, 10'd512,  10'd256, {6'h01, 8'h80, 10'd512, 10'd256}};
    vecs[3] = '{6'd63, 6'h15, 8'h5A, 10'd341,  10'd682, {6'h15, 8'h5A, 10'd341, 10'd682}};

    tick(); tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_full", 64'(bus.oam_full), 64'd0);
    chk("rst_we", 64'(bus.oam_we), 64'd0);
    chk("rst_addr", 64'(bus.oam_addr), 64'd0);
    chk("rst_data", 64'(bus.oam_data), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    rst = 1'b0;

    // Basic commit: one entry queued outside vblank.
    push(6'd5, 6'd3, 8'hA5, 10'd100, 10'd200, 1'b1);
    chk("basic_count1", 64'(bus.count), 64'd1);
    bus.vblank = 1'b1;
    tick();
    chk("basic_we_early", 64'(bus.oam_we), 64'd0);
    tick();
    chk("basic_we", 64'(bus.oam_we), 64'd1);
    chk("basic_addr", 64'(bus.oam_addr), 64'd5);
    chk("basic_data", 64'(bus.oam_data), 64'({6'd3, 8'hA5, 10'd100, 10'd200}));
    chk("basic_count0", 64'(bus.count), 64'd0);
    tick();
    chk("basic_we_once", 64'(bus.oam_we), 64'd0);
    chk("basic_addr_hold", 64'(bus.oam_addr), 64'd5);

    // Writes during vblank from DONE: two-cycle latency each.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].snum, vecs[i].idx, vecs[i].imm, vecs[i].x, vecs[i].y, 1'b1);
      chk("vb_we_early", 64'(bus.oam_we), 64'd0);
      tick();
      chk("vb_we", 64'(bus.oam_we), 64'd1);
      chk("vb_addr", 64'(bus.oam_addr), 64'(vecs[i].snum));
      chk("vb_data", 64'(bus.oam_data), 64'(vecs[i].exp_data));
      tick();
      chk("vb_we_once", 64'(bus.oam_we), 64'd0);
    end
    bus.vblank = 1'b0;
    tick();

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 8; i++)
      push(6'(i), 6'(i + 1), 8'(8'h10 + i), 10'(i * 3), 10'(i * 7), 1'b1);
    chk("fill_full", 64'(bus.oam_full), 64'd1);
    chk("fill_count", 64'(bus.count), 64'd8);
    chk("fill_ovf0", 64'(bus.overflow), 64'd0);
    push(6'd8, 6'd9, 8'hEE, 10'd1, 10'd2, 1'b0);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_count", 64'(bus.count), 64'd8);
    p0 = pulses;
    bus.vblank = 1'b1;
    wait_drain();
    chk("ovf_pulses", 64'(pulses - p0), 64'd8);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_empty", 64'(bus.count), 64'd0);
    chk("ovf_notfull", 64'(bus.oam_full), 64'd0);
    bus.vblank = 1'b0;
    tick();

    // Push into a full FIFO in the same cycle as a pop.
    do_reset();
    for (int i = 0; i < 8; i++)
      push(6'(20 + i), 6'(i), 8'(8'hC0 + i), 10'(100 + i), 10'(200 + i), 1'b1);
    p0 = pulses;
    bus.vblank = 1'b1;
    tick();
    push(6'd40, 6'd33, 8'h77, 10'd777, 10'd333, 1'b1);
    chk("pp_count", 64'(bus.count), 64'd8);
    chk("pp_ovf", 64'(bus.overflow), 64'd0);
    wait_drain();
    chk("pp_pulses", 64'(pulses - p0), 64'd9);
    bus.vblank = 1'b0;
    tick();

    // vblank falls mid-drain.
    do_reset();
    for (int i = 0; i < 6; i++)
      push(6'(10 + i), 6'(i), 8'(8'h50 + i), 10'(i), 10'(i + 500), 1'b1);
    p0 = pulses;
    bus.vblank = 1'b1;
    repeat (4) tick();
    bus.vblank = 1'b0;
    tick();
    tick();
    chk("drop_pulses", 64'(pulses - p0), 64'd3);
    chk("drop_count", 64'(bus.count), 64'd3);
    chk("drop_we_idle", 64'(bus.oam_we), 64'd0);
    bus.vblank = 1'b1;
    wait_drain();
    chk("drop_total", 64'(pulses - p0), 64'd6);
    bus.vblank = 1'b0;
    tick();

    // Reset while draining.
    do_reset();
    for (int i = 0; i < 5; i++)
      push(6'(30 + i), 6'(i), 8'h11, 10'd5, 10'd6, (i < 4) ? 1'b1 : 1'b0);
    push(6'd50, 6'd1, 8'h22, 10'd7, 10'd8, 1'b0);
    chk("rstd_ovf_set", 64'(bus.overflow), 64'd0);
    bus.vblank = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("rstd_count", 64'(bus.count), 64'd0);
    chk("rstd_we", 64'(bus.oam_we), 64'd0);
    chk("rstd_ovf", 64'(bus.overflow), 64'd0);
    p0 = pulses;
    repeat (20) tick();
    chk("rstd_no_writes", 64'(pulses - p0), 64'd0);
    chk("rstd_count_end", 64'(bus.count), 64'd0);
    bus.vblank = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
